mem16x6_arbiter: RTL and testbench

Round-robin access controller sharing one 16x6 synchronous memory between two requesters. Each requester issues read or write commands over a valid/ready handshake. The block drives the memory's address, write-enable and write-data inputs and captures its registered read data. It returns one response per accepted command, one cycle later, to the requester that issued it. It sits directly in front of the memory instance; no other logic drives the memory ports.

---
 rtl/mem16x6_arbiter_pkg.sv | 13 +
 rtl/mem16x6_arbiter_if.sv | 35 +++
 rtl/mem16x6_rr_grant.sv | 30 +++
 rtl/mem16x6_arbiter.sv | 96 +++++++++
 tb/tb_mem16x6_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem16x6_arbiter_pkg.sv
// Shared constants for the two-requester 16x6 memory arbiter.
package mem16x6_arbiter_pkg;

    localparam int AW = 4;
    localparam int DW = 6;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem16x6_arbiter_if.sv
// Request/response and memory-side bus of mem16x6_arbiter.
// Handshake: a command transfers on a rising clk edge where reqN_valid & reqN_ready;
// the requester holds valid and fields stable until then. Responses cannot be stalled.
interface mem16x6_arbiter_if;
    import mem16x6_arbiter_pkg::*;

    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic          req0_we,    req1_we;
    logic [AW-1:0] req0_addr,  req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [0:0]    state;

    modport master (
        output req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
               req0_wdata, req1_wdata, mem_rdata,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
               mem_addr, mem_we, mem_wdata, busy, state
    );

    modport slave (
        input  req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
               req0_wdata, req1_wdata, mem_rdata,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
               mem_addr, mem_we, mem_wdata, busy, state
    );

endinterface

// File: rtl/mem16x6_rr_grant.sv
// Two-way round-robin grant; `last` remembers the most recently granted requester.
module mem16x6_rr_grant (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (advance)
            last <= grant[1];
    end

endmodule

// File: rtl/mem16x6_arbiter.sv
// Round-robin access controller sharing one 16x6 synchronous memory between two requesters.
// Optional post-reset zeroing sweep enabled by defining MEM16X6_ARB_CLEAR_EN.
module mem16x6_arbiter
    import mem16x6_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mem16x6_arbiter_if.slave  bus
);

    logic [0:0]    state;
    logic          clearing;
    logic          run;
    logic [AW-1:0] sweep_addr;
    logic [1:0]    grant;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rsp_vld;
    logic          rsp_id;

`ifdef MEM16X6_ARB_CLEAR_EN
    logic [AW-1:0] sweep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            sweep <= '0;
        end else if (state == ST_CLEAR) begin
            sweep <= sweep + 1'b1;
            if (sweep == {AW{1'b1}})
                state <= ST_RUN;
        end
    end

    assign sweep_addr = sweep;
`else
    assign state      = ST_RUN;
    assign sweep_addr = '0;
`endif

    // Outputs are qualified by rst_n so every output sits at its reset value while reset is held.
    assign clearing = rst_n && (state == ST_CLEAR);
    assign run      = rst_n && (state == ST_RUN);

    mem16x6_rr_grant u_grant (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({bus.req1_valid, bus.req0_valid} & {2{run}}),
        .advance (|grant),
        .grant   (grant)
    );

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        if (clearing) begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = sweep_addr;
            bus.mem_wdata = '0;
        end else if (grant[0]) begin
            bus.mem_we    = bus.req0_we;
            bus.mem_addr  = bus.req0_addr;
            bus.mem_wdata = bus.req0_wdata;
        end else if (grant[1]) begin
            bus.mem_we    = bus.req1_we;
            bus.mem_addr  = bus.req1_addr;
            bus.mem_wdata = bus.req1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_vld <= 1'b0;
            rsp_id  <= REQ0;
        end else begin
            if (clearing || (|grant)) begin
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
            end
            rsp_vld <= |grant;
            rsp_id  <= grant[1] ? REQ1 : REQ0;
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.rsp0_valid = rsp_vld && (rsp_id == REQ0);
    assign bus.rsp1_valid = rsp_vld && (rsp_id == REQ1);
    assign bus.rsp_rdata  = rsp_vld ? bus.mem_rdata : '0;
    assign bus.busy       = clearing;
    assign bus.state      = state;

endmodule

// File: tb/tb_mem16x6_arbiter.sv
// Randomised self-checking bench for mem16x6_arbiter with a behavioural memory and arbitration model.
module tb_mem16x6_arbiter;
  import mem16x6_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem16x6_arbiter_if bus ();

  mem16x6_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference state
  logic [DW-1:0] ref_mem [16];
  int            ref_last;
  logic [DW-1:0] exp_q [$];
  logic          id_q [$];

  // pending command per requester, held until granted
  logic [1:0]    p_v;
  logic [1:0]    p_we;
  logic [AW-1:0] p_a [2];
  logic [DW-1:0] p_d [2];

  function automatic logic [DW-1:0] seed_val(int i);
    return DW'((i * 7 + 5) & 63);
  endfunction

  // behavioural 16x6 memory: registered read, read-before-write
  initial begin : mem_model
    logic [DW-1:0] tb_mem [16];
    logic [DW-1:0] rd;
    for (int i = 0; i < 16; i++) tb_mem[i] = seed_val(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      rd = tb_mem[bus.mem_addr];
      if (bus.mem_we === 1'b1) tb_mem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata <= rd;
    end
  end

  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_we = 1'b0;    bus.req1_we = 1'b0;
    bus.req0_addr = '0;    bus.req1_addr = '0;
    bus.req0_wdata = '0;   bus.req1_wdata = '0;
    p_v = 2'b00;
  endtask

  // one clock of traffic: check last cycle's response, drive, check grant, update model
  task automatic run_cycle();
    int g;
    logic [DW-1:0] ed;
    logic eid;
    if (exp_q.size() > 0) begin
      ed = exp_q.pop_front();
      eid = id_q.pop_front();
      checks++;
      if (bus.rsp0_valid !== ~eid || bus.rsp1_valid !== eid) begin
        errors++;
        $display("FAIL rsp_strobe: got rsp0=%b rsp1=%b, need rsp0=%b rsp1=%b", bus.rsp0_valid, bus.rsp1_valid, ~eid, eid);
      end
      checks++;
      if (bus.rsp_rdata !== ed) begin
        errors++;
        $display("FAIL rsp_rdata: got %h, need %h", bus.rsp_rdata, ed);
      end
    end else begin
      checks++;
      if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b00) begin
        errors++;
        $display("FAIL rsp_idle: got rsp1/rsp0=%b, need 00", {bus.rsp1_valid, bus.rsp0_valid});
      end
    end
    bus.req0_valid = p_v[0]; bus.req0_we = p_we[0]; bus.req0_addr = p_a[0]; bus.req0_wdata = p_d[0];
    bus.req1_valid = p_v[1]; bus.req1_we = p_we[1]; bus.req1_addr = p_a[1]; bus.req1_wdata = p_d[1];
    #1;
    if (p_v == 2'b11)      g = (ref_last == 0) ? 1 : 0;
    else if (p_v[0])       g = 0;
    else if (p_v[1])       g = 1;
    else                   g = -1;
    checks++;
    if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
      errors++;
      $display("FAIL ready: got r0=%b r1=%b, need grant to %0d", bus.req0_ready, bus.req1_ready, g);
    end
    checks++;
    if (bus.mem_we !== ((g >= 0) ? p_we[g] : 1'b0)) begin
      errors++;
      $display("FAIL mem_we: got %b, grant %0d", bus.mem_we, g);
    end
    if (g >= 0) begin
      checks++;
      if (bus.mem_addr !== p_a[g] || (p_we[g] && bus.mem_wdata !== p_d[g])) begin
        errors++;
        $display("FAIL mem_bus: got addr=%h wdata=%h, need addr=%h wdata=%h", bus.mem_addr, bus.mem_wdata, p_a[g], p_d[g]);
      end
      exp_q.push_back(ref_mem[p_a[g]]);
      id_q.push_back(g[0]);
      if (p_we[g]) ref_mem[p_a[g]] = p_d[g];
      ref_last = g;
      p_v[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_cmd(int r, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    p_v[r] = 1'b1; p_we[r] = we; p_a[r] = a; p_d[r] = d;
  endtask

  // release reset at a negedge and check the startup behaviour of this build
  task automatic release_reset();
    rst_n = 1'b1;
    ref_last = 1;
    exp_q.delete();
    id_q.delete();
`ifdef MEM16X6_ARB_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(i) || bus.mem_wdata !== '0 || bus.req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL sweep[%0d]: got busy=%b we=%b addr=%h wdata=%h", i, bus.busy, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
`endif
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_start: got %b, need 0", bus.busy);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    logic [31:0] obs;
    obs = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.mem_we, bus.busy,
           bus.rsp_rdata, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (obs !== 32'd0) begin
      errors++;
      $display("FAIL %s: got outputs %h, need all 0", tag, obs);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset_values");
    @(negedge clk);
    release_reset();
  endtask

  task automatic test_write_read();
    set_cmd(0, 1'b1, 4'd3, 6'h2A);
    run_cycle();
    set_cmd(0, 1'b0, 4'd3, 6'h00);
    run_cycle();
    run_cycle();
    set_cmd(1, 1'b0, 4'd7, 6'h00);
    run_cycle();
    run_cycle();
  endtask

  task automatic test_write_old();
    set_cmd(0, 1'b1, 4'd5, 6'h11);
    run_cycle();
    set_cmd(1, 1'b1, 4'd5, 6'h3F);
    run_cycle();
    set_cmd(1, 1'b0, 4'd5, 6'h00);
    run_cycle();
    run_cycle();
  endtask

  task automatic test_contention();
    for (int c = 0; c < 4; c++) begin
      if (!p_v[0]) set_cmd(0, 1'b0, 4'd1, 6'h00);
      if (!p_v[1]) set_cmd(1, 1'b0, 4'd2, 6'h00);
      run_cycle();
    end
    p_v = 2'b00;
    run_cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++)
        if (!p_v[r] && $urandom_range(0, 3) != 0)
          set_cmd(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)), DW'($urandom_range(0, 63)));
      run_cycle();
    end
    for (int c = 0; c < 4 && p_v != 2'b00; c++) run_cycle();
    run_cycle();
  endtask

  task automatic test_reset_mid();
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 4'd9;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_grant: got ready0=%b, need 1", bus.req0_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs("reset_mid_op");
    @(negedge clk);
    #1;
    check_reset_outputs("reset_mid_hold");
    @(negedge clk);
    release_reset();
    set_cmd(0, 1'b0, 4'd9, 6'h00);
    run_cycle();
    run_cycle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = seed_val(i);
    ref_last = 1;
    p_we = 2'b00;
    p_a[0] = '0; p_a[1] = '0; p_d[0] = '0; p_d[1] = '0;
    test_reset();
    test_write_read();
    test_write_old();
    test_contention();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
